// File: rtl/gps_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// gps_feeder : buffers GPS points, feeds consecutive pairs to a distance calc
// Revision   : 1.0
// ----------------------------------------------------------------------------
module gps_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [23:0] pt_lon,
  input  logic [23:0] pt_lat,
  output logic        den,
  output logic [23:0] lon_out,
  output logic [23:0] lat_out,
  input  logic        calc_valid,
  input  logic [63:0] calc_a,
  input  logic [39:0] calc_d,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_a,
  output logic [39:0] res_d,
  output logic        res_err,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PAIR_CNT  = CW'(2);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  state_t        state;
  logic [47:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [23:0]   last_lon;
  logic [23:0]   last_lat;
  logic [23:0]   head_lon;
  logic [23:0]   head_lat;
  logic          push;
  logic          pop;
  logic          timed_out;

  assign pt_ready  = (count != DEPTH_CNT);
  assign push      = pt_valid & pt_ready;
  assign timed_out = (timer == TIMER_MAX);
  // Point A leaves on the SEND_A exit, point B on either HOLD_B exit.
  assign pop       = (state == SEND_A) | ((state == HOLD_B) & (calc_valid | timed_out));
  assign {head_lon, head_lat} = mem[rd_ptr];

  assign busy    = (state != IDLE);
  assign den     = (state == SEND_A) | ((state == HOLD_B) & ~calc_valid);
  assign lon_out = busy ? head_lon : last_lon;
  assign lat_out = busy ? head_lat : last_lat;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pt_lon, pt_lat};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Result buffer holds one entry; a pending result blocks the next pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      last_lon  <= '0;
      last_lat  <= '0;
      res_valid <= 1'b0;
      res_a     <= '0;
      res_d     <= '0;
      res_err   <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (busy) begin
        last_lon <= head_lon;
        last_lat <= head_lat;
      end
      case (state)
        IDLE: begin
          if ((count >= PAIR_CNT) && !res_valid) state <= SEND_A;
        end
        SEND_A: begin
          timer <= '0;
          state <= HOLD_B;
        end
        HOLD_B: begin
          if (calc_valid) begin
            res_a     <= calc_a;
            res_d     <= calc_d;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            timer     <= '0;
            state     <= IDLE;
          end else if (timed_out) begin
            res_a     <= '0;
            res_d     <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            timer     <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gps_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_gps_feeder : directed scenarios; a queue-based reference model is compared every cycle.
module tb_gps_feeder;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pt_valid, pt_ready;
  logic [23:0] pt_lon, pt_lat;
  logic        den;
  logic [23:0] lon_out, lat_out;
  logic        calc_valid;
  logic [63:0] calc_a;
  logic [39:0] calc_d;
  logic        res_valid, res_ready;
  logic [63:0] res_a;
  logic [39:0] res_d;
  logic        res_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  gps_feeder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_lon(pt_lon), .pt_lat(pt_lat),
    .den(den), .lon_out(lon_out), .lat_out(lat_out),
    .calc_valid(calc_valid), .calc_a(calc_a), .calc_d(calc_d),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_d(res_d), .res_err(res_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: pair_age -1 = no pair, 0 = presenting A, k>=1 = B held for k-1 cycles
  logic [47:0] m_q[$];
  int          m_age = -1;
  logic        m_rv = 1'b0;
  logic [63:0] m_ra = '0;
  logic [39:0] m_rd = '0;
  logic        m_re = 1'b0;
  logic [23:0] m_lon = '0;
  logic [23:0] m_lat = '0;
  int          m_res_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_age = -1; m_rv = 1'b0; m_ra = '0; m_rd = '0; m_re = 1'b0;
      m_lon = '0; m_lat = '0;
    end else begin
      bit          take;
      bit          rv_old;
      logic [47:0] dropped;
      take   = pt_valid && (m_q.size() < DEPTH);
      rv_old = m_rv;
      if (m_rv && res_ready) m_rv = 1'b0;
      if (m_age < 0) begin
        if (m_q.size() >= 2 && !rv_old) m_age = 0;
      end else begin
        {m_lon, m_lat} = m_q[0];
        if (m_age == 0) begin
          dropped = m_q.pop_front();
          m_age = 1;
        end else if (calc_valid) begin
          dropped = m_q.pop_front();
          m_rv = 1'b1; m_ra = calc_a; m_rd = calc_d; m_re = 1'b0;
          m_age = -1; m_res_cnt++;
        end else if (m_age - 1 == TMO) begin
          dropped = m_q.pop_front();
          m_rv = 1'b1; m_ra = '0; m_rd = '0; m_re = 1'b1;
          m_age = -1; m_res_cnt++;
        end else begin
          m_age++;
        end
      end
      if (take) m_q.push_back({pt_lon, pt_lat});
    end
  end

  always @(negedge clk) begin
    logic [23:0] elon, elat;
    if (run_cmp) begin
      if (m_age >= 0) {elon, elat} = m_q[0];
      else begin elon = m_lon; elat = m_lat; end
      chk("cyc_pt_ready", 64'(pt_ready), 64'(m_q.size() < DEPTH));
      chk("cyc_busy", 64'(busy), 64'(m_age >= 0));
      chk("cyc_den", 64'(den), 64'((m_age == 0) || (m_age > 0 && !calc_valid)));
      chk("cyc_lon_out", 64'(lon_out), 64'(elon));
      chk("cyc_lat_out", 64'(lat_out), 64'(elat));
      chk("cyc_res_valid", 64'(res_valid), 64'(m_rv));
      chk("cyc_res_a", res_a, m_ra);
      chk("cyc_res_d", 64'(res_d), 64'(m_rd));
      chk("cyc_res_err", 64'(res_err), 64'(m_re));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pt(input logic [23:0] lon, input logic [23:0] lat);
    int   t = 0;
    logic acc;
    pt_valid = 1'b1; pt_lon = lon; pt_lat = lat;
    do begin
      acc = pt_ready;
      tick();
      t++;
    end while (!acc && t < 200);
    pt_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_wait: pt_ready stayed 0 for %0d cycles, required 1", t);
    end
  endtask

  task automatic wait_busy();
    int t = 0;
    while (!busy && t < 60) begin tick(); t++; end
    if (!busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_wait: busy 0 after %0d cycles, required 1", t);
    end
  endtask

  // Answers the pending pair once the hold timer has reached 'hold'; reports point B.
  task automatic serve(input logic [63:0] a, input logic [39:0] d, input int hold,
                       output logic [23:0] lonb);
    wait_busy();
    tick();
    repeat (hold) tick();
    calc_valid = 1'b1; calc_a = a; calc_d = d;
    lonb = lon_out;
    tick();
    calc_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [23:0] lb;
    int n, base_cnt;
    reset_n = 1'b0; pt_valid = 1'b0; pt_lon = '0; pt_lat = '0;
    calc_valid = 1'b0; calc_a = '0; calc_d = '0; res_ready = 1'b0;
    repeat (3) tick();
    run_cmp = 1'b1;
    tick();
    chk("rst_den", 64'(den), 64'd0);
    chk("rst_pt_ready", 64'(pt_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_lon_out", 64'(lon_out), 64'd0);
    chk("rst_res_a", res_a, 64'd0);
    reset_n = 1'b1;
    tick();

    // basic pair with literal expectations
    push_pt(24'h780000, 24'h170000);
    push_pt(24'h790000, 24'h180000);
    tick();
    chk("s1_den_a", 64'(den), 64'd1);
    chk("s1_lon_a", 64'(lon_out), 64'h780000);
    chk("s1_lat_a", 64'(lat_out), 64'h170000);
    tick();
    chk("s1_den_b", 64'(den), 64'd1);
    chk("s1_lon_b", 64'(lon_out), 64'h790000);
    chk("s1_lat_b", 64'(lat_out), 64'h180000);
    repeat (9) tick();
    calc_valid = 1'b1; calc_a = 64'h1234; calc_d = 40'h56;
    #1;
    chk("s1_den_calc", 64'(den), 64'd0);
    tick();
    calc_valid = 1'b0;
    chk("s1_res_valid", 64'(res_valid), 64'd1);
    chk("s1_res_a", res_a, 64'h1234);
    chk("s1_res_d", 64'(res_d), 64'h56);
    chk("s1_res_err", 64'(res_err), 64'd0);
    chk("s1_idle_lon", 64'(lon_out), 64'h790000);
    calc_valid = 1'b1; calc_a = 64'hFFFF;
    tick();
    calc_valid = 1'b0;
    chk("s1_idle_calc_ign", res_a, 64'h1234);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("s1_res_cleared", 64'(res_valid), 64'd0);

    // pending result holds the next pair; fill FIFO to full
    for (int i = 0; i < 4; i++) push_pt(24'h200000 + 24'(i), 24'h300000 + 24'(i));
    serve(64'hA1, 40'hB1, 3, lb);
    chk("s2_lon_b0", 64'(lb), 64'h200001);
    repeat (3) tick();
    chk("s2_hold_busy", 64'(busy), 64'd0);
    chk("s2_hold_den", 64'(den), 64'd0);
    push_pt(24'h200004, 24'h300004);
    push_pt(24'h200005, 24'h300005);
    chk("s2_full", 64'(pt_ready), 64'd0);
    pt_valid = 1'b1; pt_lon = 24'hDEAD00; pt_lat = 24'hBEEF00;
    tick(); tick();
    pt_valid = 1'b0;
    chk("s2_full_busy", 64'(busy), 64'd0);
    res_ready = 1'b1;
    serve(64'hA2, 40'hB2, 2, lb);
    chk("s2_lon_b1", 64'(lb), 64'h200003);
    serve(64'hA3, 40'hB3, 0, lb);
    chk("s2_lon_b2", 64'(lb), 64'h200005);
    repeat (3) tick();
    res_ready = 1'b0;

    // timeout: result exactly 256 cycles after HOLD_B entry
    push_pt(24'h400000, 24'h410000);
    push_pt(24'h400001, 24'h410001);
    push_pt(24'h400002, 24'h410002);
    wait_busy();
    tick();
    n = 0;
    while (!res_valid && n < 400) begin tick(); n++; end
    chk("s3_timeout_cycles", 64'(n), 64'd256);
    chk("s3_res_err", 64'(res_err), 64'd1);
    chk("s3_res_a", res_a, 64'd0);
    chk("s3_res_d", 64'(res_d), 64'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    repeat (3) tick();
    chk("s3_one_left", 64'(busy), 64'd0);

    // calc_valid on the timeout cycle wins
    push_pt(24'h400003, 24'h410003);
    serve(64'hCAFE, 40'hBEEF, TMO, lb);
    chk("s4_lon_b", 64'(lb), 64'h400003);
    chk("s4_res_err", 64'(res_err), 64'd0);
    chk("s4_res_a", res_a, 64'hCAFE);
    chk("s4_res_d", 64'(res_d), 64'hBEEF);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // reset in HOLD_B
    push_pt(24'h600000, 24'h610000);
    push_pt(24'h600001, 24'h610001);
    wait_busy();
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("s5_den", 64'(den), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_pt_ready", 64'(pt_ready), 64'd1);
    chk("s5_res_valid", 64'(res_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    calc_valid = 1'b1; calc_a = 64'h9;
    tick();
    calc_valid = 1'b0;
    chk("s5_calc_ign", 64'(res_valid), 64'd0);
    push_pt(24'h600002, 24'h610002);
    repeat (5) tick();
    chk("s5_no_den", 64'(den), 64'd0);
    res_ready = 1'b1;
    push_pt(24'h600003, 24'h610003);
    serve(64'h77, 40'h77, 1, lb);
    chk("s5_lon_b", 64'(lb), 64'h600003);
    repeat (3) tick();

    // streaming across pointer wrap
    base_cnt = m_res_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) push_pt(24'h100000 + 24'(i), 24'h500000 + 24'(i));
      end
      begin
        for (int k = 0; k < 10; k++) begin
          logic [23:0] lbk;
          serve(64'(k) + 64'h100, 40'(k), 2, lbk);
          chk("s6_lon_b", 64'(lbk), 64'h100000 + 64'(2 * k + 1));
        end
      end
    join
    repeat (4) tick();
    chk("s6_results", 64'(m_res_cnt - base_cnt), 64'd10);
    chk("s6_drained", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gps_feeder.md
GPS_FEEDER -- requirements
Module: gps_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, point FIFO entries (power of 2, >=2).
REQ-002 Parameter TIMEOUT, default 255, max cycles in HOLD_B before abort.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 pt_valid  input  1  upstream point valid.
REQ-006 pt_ready  output  1  FIFO not full (registered count based).
REQ-007 pt_lon / pt_lat  input  24 each  upstream longitude / latitude.
REQ-008 den  output  1  data-enable to distance calculator.
REQ-009 lon_out / lat_out  output  24 each  coordinates driven to calculator.
REQ-010 calc_valid  input  1  calculator result strobe (one cycle).
REQ-011 calc_a  input  64, calc_d  input  40  calculator results.
REQ-012 res_valid  output  1, res_ready  input  1  result handshake.
REQ-013 res_a  output  64, res_d  output  40, res_err  output  1  captured result, timeout flag.
REQ-014 busy  output  1  high when FSM not in IDLE.

Function
REQ-015 Point FIFO SHALL write on pt_valid&&pt_ready; pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL be impossible (pt_ready low).
REQ-017 FSM states SHALL be IDLE, SEND_A, HOLD_B.
REQ-018 IDLE -> SEND_A when count>=2 and res_valid==0; otherwise stay.
REQ-019 SEND_A: den=1, lon_out/lat_out = FIFO head (point A) for exactly one cycle; head popped; -> HOLD_B.
REQ-020 HOLD_B: lon_out/lat_out = FIFO head (point B); den = ~calc_valid (combinational gate); timer increments each cycle.
REQ-021 HOLD_B with calc_valid=1: pop B, load res_a<=calc_a, res_d<=calc_d, res_err<=0, res_valid<=1, clear timer, -> IDLE.
REQ-022 HOLD_B with timer==TIMEOUT and calc_valid=0: pop B, res_a<=0, res_d<=0, res_err<=1, res_valid<=1, -> IDLE.
REQ-023 calc_valid and timeout in same cycle: calc_valid SHALL win (res_err=0).
REQ-024 den SHALL be 0 in IDLE; lon_out/lat_out hold last driven value in IDLE.
REQ-025 calc_valid in IDLE or SEND_A SHALL be ignored (no capture, no state change).
REQ-026 res_valid SHALL clear on res_valid&&res_ready; result regs hold until next capture.
REQ-027 New pair SHALL NOT start while res_valid==1 (one-entry result buffer, no overwrite).
REQ-028 Latency: push of second point at edge N -> den high (A) in cycle N+1 -> den high (B) from cycle N+2 until calc_valid cycle.
REQ-029 Timer width SHALL be ceil(log2(TIMEOUT+1)) bits, never wraps.
REQ-030 Pop in SEND_A/HOLD_B exit SHALL coexist with same-cycle upstream push per REQ-016.

Reset
REQ-031 reset_n low SHALL asynchronously set: FSM IDLE, FIFO empty (pointers, count 0), timer 0.
REQ-032 Reset values: den=0, lon_out=0, lat_out=0, res_valid=0, res_a=0, res_d=0, res_err=0, busy=0, pt_ready=1.
REQ-033 Reset mid-pair (SEND_A or HOLD_B) SHALL discard all FIFO points and any pending result; no den after release until two new points pushed.

Verification
REQ-034 Push A=(lon 0x780000, lat 0x170000), B=(0x790000, 0x180000) back-to-back -> den one cycle with A, then den with B held; calc_valid with a=0x1234, d=0x56 after 10 cycles -> den low that cycle, res_valid=1, res_a=0x1234, res_d=0x56, res_err=0.
REQ-035 Push 4 points with res_ready=0 -> first pair processed, second pair held in IDLE (busy=0, den=0) until res_ready pulses; pt_ready=0 when 4 stored before first pop.
REQ-036 Push one pair, never assert calc_valid, TIMEOUT=255 -> res_valid with res_err=1, res_a=0, res_d=0 exactly 256 cycles after HOLD_B entry; FIFO count decremented by 2.
REQ-037 calc_valid asserted on the cycle timer==TIMEOUT -> res_err=0, results captured.
REQ-038 Assert reset_n low during HOLD_B -> den=0 immediately, FIFO empty, res_valid=0; a later calc_valid ignored.
REQ-039 Continuous push/pop at full occupancy across pointer wrap (20 points) -> 10 results, coordinates delivered in push order.
